// File: rtl/fifo_dram_ctrl_pkg.sv
// rtl/fifo_dram_ctrl_pkg.sv - shared length codes, line geometry and state encoding
package fifo_dram_ctrl_pkg;

  // Packer length codes; a larger code means a shorter push.
  localparam logic [3:0] LEN_HOLD = 4'd0;
  localparam logic [3:0] LEN_64   = 4'd1;
  localparam logic [3:0] LEN_48   = 4'd2;
  localparam logic [3:0] LEN_32   = 4'd3;
  localparam logic [3:0] LEN_16   = 4'd4;

  // A line is 17 units of 16 bits (272 bits).
  localparam int UNIT_BITS  = 16;
  localparam int LINE_UNITS = 17;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_dram_len_decode.sv
// rtl/fifo_dram_len_decode.sv - length code to fill-unit count plus validity flag
module fifo_dram_len_decode
  import fifo_dram_ctrl_pkg::*;
#(
  parameter int UW = 3
) (
  input  logic [3:0]    len,
  output logic [UW-1:0] units,
  output logic          valid
);

  // Map each legal length code to its unit count; anything else counts as zero units.
  always_comb begin
    units = '0;
    case (len)
      LEN_16:  units = UW'(1);
      LEN_32:  units = UW'(2);
      LEN_48:  units = UW'(3);
      LEN_64:  units = UW'(4);
      default: units = '0;
    endcase
    valid = (units != '0);
  end

endmodule

// File: rtl/fifo_dram_ctrl.sv
// rtl/fifo_dram_ctrl.sv - sequencing controller for the 272-bit line packer
module fifo_dram_ctrl #(
  parameter int UNIT_BITS  = 16,
  parameter int LINE_UNITS = 17,
  parameter int CNT_W      = 5,
  parameter int LCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic [3:0]        in_len,
  input  logic              in_inv,
  input  logic              flush,
  output logic [63:0]       pk_din,
  output logic [3:0]        pk_len,
  output logic              pk_inv,
  output logic              pk_ce,
  output logic              line_valid,
  input  logic              line_ready,
  output logic [4:0]        line_pad,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              err_len
);

  import fifo_dram_ctrl_pkg::state_t;
  import fifo_dram_ctrl_pkg::ST_FILL;
  import fifo_dram_ctrl_pkg::ST_PAD;
  import fifo_dram_ctrl_pkg::ST_EMIT;
  import fifo_dram_ctrl_pkg::LEN_HOLD;
  import fifo_dram_ctrl_pkg::LEN_16;

  // A 64-bit push carries at most this many units.
  localparam int PUSH_UNITS_MAX = 64 / UNIT_BITS;
  localparam int UW             = $clog2(PUSH_UNITS_MAX + 1);

  logic [UW-1:0]     units;
  logic              len_ok;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  fill, fill_nxt;
  logic [4:0]        pad_nxt;
  logic [LCNT_W-1:0] cnt_nxt;
  logic              pend, pend_nxt;
  logic              err_nxt;
  logic              push;
  logic [CNT_W:0]    fill_sum;
  logic              fits;

  fifo_dram_len_decode #(.UW(UW)) u_len_decode (
    .len   (in_len),
    .units (units),
    .valid (len_ok)
  );

  assign fill_sum = {1'b0, fill} + (CNT_W+1)'(units);
  assign fits     = (fill_sum <= (CNT_W+1)'(LINE_UNITS));

  // State register and line bookkeeping; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      fill     <= '0;
      pend     <= 1'b0;
      line_pad <= '0;
      line_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill     <= fill_nxt;
      pend     <= pend_nxt;
      line_pad <= pad_nxt;
      line_cnt <= cnt_nxt;
      err_len  <= err_nxt;
    end
  end

  // Next-state and packer drive; outputs are forced low while reset is held.
  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill;
    pad_nxt    = line_pad;
    cnt_nxt    = line_cnt;
    pend_nxt   = pend;
    err_nxt    = 1'b0;
    push       = 1'b0;
    in_ready   = 1'b0;
    pk_din     = '0;
    pk_len     = LEN_HOLD;
    pk_inv     = 1'b0;
    pk_ce      = 1'b0;
    line_valid = 1'b0;
    if (!rst) begin
      case (state)
        ST_FILL: begin
          in_ready = fits || !len_ok;
          push     = in_valid && len_ok && fits;
          err_nxt  = in_valid && !len_ok;
          if (push) begin
            pk_din   = in_data;
            pk_len   = in_len;
            pk_inv   = in_inv;
            pk_ce    = 1'b1;
            fill_nxt = fill_sum[CNT_W-1:0];
          end
          if (flush) pend_nxt = 1'b1;
          // A completed line wins, then a misfit auto-close, then a pending flush.
          if (push && fill_sum == (CNT_W+1)'(LINE_UNITS)) begin
            state_nxt = ST_EMIT;
          end else if (in_valid && len_ok && !fits) begin
            state_nxt = ST_PAD;
          end else if (flush || pend) begin
            if (fill_nxt == '0) pend_nxt = 1'b0;
            else                state_nxt = ST_PAD;
          end
        end
        ST_PAD: begin
          pk_len   = LEN_16;
          pk_ce    = 1'b1;
          fill_nxt = fill + CNT_W'(1);
          pad_nxt  = line_pad + 5'd1;
          if (fill == CNT_W'(LINE_UNITS - 1)) state_nxt = ST_EMIT;
        end
        ST_EMIT: begin
          line_valid = 1'b1;
          if (line_ready) begin
            fill_nxt  = '0;
            pad_nxt   = '0;
            cnt_nxt   = line_cnt + LCNT_W'(1);
            pend_nxt  = 1'b0;
            state_nxt = ST_FILL;
          end
        end
        default: state_nxt = ST_FILL;
      endcase
    end
  end

  // Fill must never run past a full line.
  always @(posedge clk) begin
    if (!rst) assert (fill <= CNT_W'(LINE_UNITS));
  end

endmodule
